tx_startup_ctrl: RTL

TX_STARTUP_CTRL -- requirements
Module: tx_startup_ctrl

---
 rtl/tx_ctrl_pkg.sv | 14 +
 rtl/tx_err_sched.sv | 53 +++++
 rtl/tx_startup_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/tx_ctrl_pkg.sv
// rtl/tx_ctrl_pkg.sv - shared state type and defaults for the TX startup controller
package tx_ctrl_pkg;

  localparam int TX_WAIT_CYC_DEF = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIV_REL  = 3'd1,
    MUX_REL  = 3'd2,
    PRBS_REL = 3'd3,
    RUN      = 3'd4
  } tx_ctrl_state_t;

endpackage

// File: rtl/tx_err_sched.sv
// rtl/tx_err_sched.sv - periodic/requested PRBS error scheduler with saturating counter
module tx_err_sched #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             err_req,
  input  logic [PER_W-1:0] err_period,
  output logic             inj_error,
  output logic [15:0]      err_cnt
);

  localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};

  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic             inj_q, inj_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             per_hit;

  // Period counter compares against the live err_period so a shrinking period fires at once;
  // request and periodic events merge into a single pulse and a single count.
  always_comb begin
    per_hit   = 1'b0;
    per_cnt_d = '0;
    if (active && (err_period != '0)) begin
      per_hit   = (per_cnt_q >= (err_period - PER_ONE));
      per_cnt_d = per_hit ? '0 : (per_cnt_q + PER_ONE);
    end
    inj_d     = active && (err_req || per_hit);
    err_cnt_d = err_cnt_q;
    if (inj_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Scheduler registers; the error count is cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q <= '0;
      inj_q     <= 1'b0;
      err_cnt_q <= 16'd0;
    end else begin
      per_cnt_q <= per_cnt_d;
      inj_q     <= inj_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign inj_error = inj_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: rtl/tx_startup_ctrl.sv
// rtl/tx_startup_ctrl.sv - staged reset release for divider, mux pair and PRBS generators
module tx_startup_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int WAIT_CYC = TX_WAIT_CYC_DEF,
  parameter int PER_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             err_req,
  input  logic [PER_W-1:0] err_period,
  output logic             rst_div,
  output logic             rst_mux,
  output logic             rst_prbs,
  output logic             inj_error,
  output logic             ready,
  output logic [15:0]      err_cnt
);

  localparam logic [15:0] STAGE_LAST = 16'(WAIT_CYC - 1);

  tx_ctrl_state_t state_q, state_d;
  logic [15:0]    stage_q, stage_d;
  logic           rst_div_q, rst_div_d;
  logic           rst_mux_q, rst_mux_d;
  logic           rst_prbs_q, rst_prbs_d;
  logic           ready_q, ready_d;
  logic           sched_active;

  // Next state and stage timer; stop wins over everything, and the timer restarts on every entry.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q + 16'd1;
    if (stop) begin
      state_d = IDLE;
      stage_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          stage_d = '0;
          if (start) state_d = DIV_REL;
        end
        DIV_REL: if (stage_q == STAGE_LAST) begin
          state_d = MUX_REL;
          stage_d = '0;
        end
        MUX_REL: if (stage_q == STAGE_LAST) begin
          state_d = PRBS_REL;
          stage_d = '0;
        end
        PRBS_REL: if (stage_q == STAGE_LAST) begin
          state_d = RUN;
          stage_d = '0;
        end
        RUN: stage_d = '0;
        default: begin
          state_d = IDLE;
          stage_d = '0;
        end
      endcase
    end
    rst_div_d    = (state_d == IDLE);
    rst_mux_d    = (state_d == IDLE) || (state_d == DIV_REL);
    rst_prbs_d   = (state_d == IDLE) || (state_d == DIV_REL) || (state_d == MUX_REL);
    ready_d      = (state_d == RUN);
    sched_active = (state_q == RUN) && (state_d == RUN);
  end

  // State register and outputs decoded from the next state, so each output moves with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      rst_div_q  <= 1'b1;
      rst_mux_q  <= 1'b1;
      rst_prbs_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      rst_div_q  <= rst_div_d;
      rst_mux_q  <= rst_mux_d;
      rst_prbs_q <= rst_prbs_d;
      ready_q    <= ready_d;
    end
  end

  tx_err_sched #(.PER_W(PER_W)) u_sched (
    .clk        (clk),
    .rst        (rst),
    .active     (sched_active),
    .err_req    (err_req),
    .err_period (err_period),
    .inj_error  (inj_error),
    .err_cnt    (err_cnt)
  );

  assign rst_div  = rst_div_q;
  assign rst_mux  = rst_mux_q;
  assign rst_prbs = rst_prbs_q;
  assign ready    = ready_q;

endmodule
